mmu: RTL and testbench
======================

// Module: mmu
// PURPOSE
// - Memory-mapped bus fabric between the Vicuna/Ibex data port and the SoC peripherals:
//   internal SRAM, 10-pin GPIO, digital timer, and read-only external SPI flash.
// - Also hosts an SPI slave that loads SRAM (programming mode) or reads it back (debug mode).
// - One request is outstanding at a time; every request completes with one rvalid pulse.
// PARAMETERS
// - SRAM_WORDS   1024  number of 32-bit SRAM words (4 KiB); SRAM word index = addr[11:2]
// - SPI_CLK_DIV  2     clk cycles per flash sck period (even, >=2)
// PORTS
// - clk                        in     1   clock; all logic is on posedge clk
// - rst                        in     1   reset: synchronous, active-high
// - set_programming_mode       in     1   level; SPI slave writes SRAM, CPU access is blocked
// - set_debug_mode             in     1   level; SPI slave reads SRAM back (no writes)
// - vproc_mem_req_o            in     1   CPU request strobe, one cycle
// - vproc_mem_addr_o           in     32  byte address
// - vproc_mem_we_o             in     1   1 = write, 0 = read
// - vproc_mem_be_o             in     4   byte enables
// - vproc_mem_wdata_o          in     32  write data
// - vproc_mem_rvalid_i         out    1   response valid, one-cycle pulse
// - vproc_mem_err_i            out    1   error flag, qualified by rvalid
// - vproc_mem_rdata_i          out    32  read data, qualified by rvalid
// - timer_is_high              in     1   timer status
// - timer_set_val              out    32  timer reload value
// - set_timer                  out    1   one-cycle load strobe for the timer
// - external_storage_spi_cs_n  out    1   flash chip select
// - external_storage_spi_sck   out    1   flash clock
// - external_storage_spi_mosi  out    1   flash data out
// - external_storage_spi_miso  in     1   flash data in
// - programming_spi_cs_n       in     1   slave chip select
// - programming_spi_sck        in     1   slave clock
// - programming_spi_mosi       in     1   slave data in
// - programming_spi_miso       out    1   slave data out
// - gpio_pins                  inout  10  GPIO pads
// BEHAVIOUR
// - Reset: every output is 0 except external_storage_spi_cs_n = 1. GPIO_OUT and GPIO_OE are 0,
//   so the pins are high-Z. The FSM returns to IDLE. SRAM contents are not cleared.
// - Memory map (addr[1:0] is ignored):
//   - 0x0000_0000-0x0000_0FFF  SRAM, read/write. Writes honour be.
//   - 0x1000_0000  GPIO_OUT, bits [9:0], read/write.
//   - 0x1000_0004  GPIO_OE, bits [9:0], read/write. gpio_pins[i] = OE[i] ? OUT[i] : 'z.
//   - 0x1000_0008  GPIO_IN, read-only. Returns gpio_pins through a 2-flop synchronizer.
//   - 0x2000_0000  TIMER. Write: timer_set_val <= wdata and set_timer pulses for 1 cycle.
//     Read: {31'b0, timer_is_high}.
//   - 0x3000_0000-0x3FFF_FFFF  flash, read-only; flash address = addr[23:0].
//   - Every other address is reserved: rvalid with err=1 and rdata=0.
// - For GPIO and TIMER, be is ignored and writes are full-word.
// - Latency for SRAM, GPIO, TIMER, reserved addresses and errors: rvalid exactly 1 cycle after req.
//   Write responses carry rdata=0.
// - Errors (rvalid with err=1 and no side effect):
//   - a write to flash or to GPIO_IN;
//   - any CPU request while set_programming_mode or set_debug_mode is high.
// - Flash FSM states: IDLE -> CMD -> ADDR -> DATA -> DONE -> IDLE.
//   - SPI mode 0, MSB first; cs_n goes low one cycle before the first sck edge.
//   - CMD sends 8 bits 0x03; ADDR sends 24 bits; DATA samples 32 bits on rising sck.
//   - Byte k received forms rdata[8k+7:8k], so the first byte lands in [7:0].
//   - DONE raises cs_n and pulses rvalid.
// - Only one request may be outstanding. A req that arrives while the FSM is not IDLE is dropped:
//   no response and no side effect.
// - A rst during a flash transfer aborts it immediately: cs_n=1, sck=0, no rvalid.
// - SPI slave synchronisation: sck, cs_n and mosi each pass through a 2-flop synchronizer.
//   Edges are detected on the synchronized sck.
// - SPI slave framing: cs_n=1 clears the bit counter and the shift register.
//   Mode 0: sample on sck rise, shift miso on sck fall.
// - Programming mode frame is 64 bits: 32-bit byte address, then 32-bit data.
//   After bit 64 the full word is written to SRAM[addr[11:2]]; the counter then wraps, so frames
//   may be back-to-back.
// - Debug mode frame: 32 address bits in, then SRAM[addr[11:2]] out on miso, MSB first, over the
//   next 32 sck periods. miso is 0 at all other times.
// - If both mode inputs are high, programming mode wins.
// - SRAM port priority: the SPI slave has priority, which is safe because the CPU is blocked in
//   both modes.
// STRUCTURE
// - Package mmu_pkg holds:
//   - address base/mask localparams for SRAM, GPIO, TIMER and FLASH;
//   - GPIO register offsets and the flash read opcode 0x03;
//   - typedef enum flash_state_t.
// - Sub-module spi_flash_reader: SPI master with a start/addr in and done/data out handshake.
//   Everything else stays in mmu: decode, GPIO, timer, SRAM array, SPI slave.
// TESTING
// - SRAM: write 0xDEADBEEF at 0x10 with be=4'b0011, then read 0x10.
//   -> rvalid 1 cycle later, rdata=0x0000BEEF, err=0.
// - GPIO: write GPIO_OE=0x3FF and GPIO_OUT=0x155 -> gpio_pins=10'h155.
//   Then write OE=0, drive the pins to 0x2AA externally and read GPIO_IN -> 0x000002AA.
// - Timer: write 0x1234 to 0x2000_0000 -> timer_set_val=0x1234 with set_timer high for exactly
//   1 cycle. With timer_is_high=1, a read returns 1.
// - Flash: read 0x3000_0100 from a flash model returning bytes 11,22,33,44.
//   -> mosi carries 0x03 then 0x000100; rdata=0x44332211; cs_n returns to 1.
// - Reserved/illegal: read 0x4000_0000, write flash, or request with programming mode high.
//   -> err=1 each time, no state change.
// - Programming mode: send 64-bit frame addr=0x20, data=0xCAFEF00D. Drop the mode and read 0x20
//   -> 0xCAFEF00D. In debug mode the same address shifts 0xCAFEF00D out on miso.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared address map, register offsets, flash opcode and FSM/decode types
// for the mmu bus fabric.
package mmu_pkg;

  localparam logic [31:0] SRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_BASE  = 32'h1000_0000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] TIMER_BASE = 32'h2000_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] FLASH_BASE = 32'h3000_0000;
  localparam logic [31:0] FLASH_MASK = 32'hF000_0000;

  localparam logic [3:0] GPIO_OUT_OFS = 4'h0;
  localparam logic [3:0] GPIO_OE_OFS  = 4'h4;
  localparam logic [3:0] GPIO_IN_OFS  = 4'h8;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;

  typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_DATA, F_DONE} flash_state_t;

  typedef enum logic [2:0] {
    T_SRAM, T_GPIO_OUT, T_GPIO_OE, T_GPIO_IN, T_TIMER, T_FLASH, T_RSVD
  } target_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  // addr[1:0] never takes part in a match: all masks clear those bits.
  function automatic target_t decode(input logic [31:0] addr);
    target_t t;
    t = T_RSVD;
    if ((addr & SRAM_MASK) == SRAM_BASE) t = T_SRAM;
    else if ((addr & GPIO_MASK) == GPIO_BASE) begin
      case ({addr[3:2], 2'b00})
        GPIO_OUT_OFS: t = T_GPIO_OUT;
        GPIO_OE_OFS:  t = T_GPIO_OE;
        GPIO_IN_OFS:  t = T_GPIO_IN;
        default:      t = T_RSVD;
      endcase
    end
    else if ((addr & TIMER_MASK) == TIMER_BASE) t = T_TIMER;
    else if ((addr & FLASH_MASK) == FLASH_BASE) t = T_FLASH;
    return t;
  endfunction

endpackage

// File: rtl/mmu_spi_flash_reader.sv
// SPI mode-0 master issuing a single 0x03 read (cmd, 24-bit addr, 32 data bits).
// start is taken only in IDLE; done is high for the one DONE cycle.
module spi_flash_reader
  import mmu_pkg::*;
#(
  parameter int SPI_CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] data,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  localparam int HALF = SPI_CLK_DIV / 2;

  flash_state_t state, state_nx;
  logic [7:0]   div_cnt;
  logic [5:0]   bit_cnt;
  logic [31:0]  tx, rx;
  logic         tick, fall;

  assign tick = (div_cnt == 8'(HALF - 1));
  assign fall = tick & sck;
  assign busy = (state != F_IDLE);
  assign done = (state == F_DONE);
  assign mosi = tx[31];
  // Bytes arrive MSB first; the first byte received is the least significant.
  assign data = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};

  always_ff @(posedge clk) begin
    if (rst) state <= F_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      F_IDLE:  if (start) state_nx = F_CMD;
      F_CMD:   if (fall && bit_cnt == 6'd7)  state_nx = F_ADDR;
      F_ADDR:  if (fall && bit_cnt == 6'd31) state_nx = F_DATA;
      F_DATA:  if (fall && bit_cnt == 6'd63) state_nx = F_DONE;
      F_DONE:  state_nx = F_IDLE;
      default: state_nx = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      unique case (state)
        F_IDLE: if (start) begin
          cs_n    <= 1'b0;
          sck     <= 1'b0;
          tx      <= {FLASH_READ_CMD, addr};
          bit_cnt <= '0;
          // Preloaded so the first sck edge lands one cycle after cs_n drops.
          div_cnt <= 8'(HALF - 1);
        end
        F_DONE: begin
          cs_n <= 1'b1;
          sck  <= 1'b0;
        end
        default: begin
          if (!tick) div_cnt <= div_cnt + 8'd1;
          else begin
            div_cnt <= '0;
            sck     <= ~sck;
            if (!sck) begin
              if (state == F_DATA) rx <= {rx[30:0], miso};
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              tx      <= {tx[30:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mmu.sv
// Bus fabric for the CPU data port: SRAM, GPIO, timer, SPI flash reads,
// plus an SPI slave that programs or dumps SRAM.
module mmu
  import mmu_pkg::*;
#(
  parameter int SRAM_WORDS  = 1024,
  parameter int SPI_CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_programming_mode,
  input  logic        set_debug_mode,
  input  logic        vproc_mem_req_o,
  input  logic [31:0] vproc_mem_addr_o,
  input  logic        vproc_mem_we_o,
  input  logic [3:0]  vproc_mem_be_o,
  input  logic [31:0] vproc_mem_wdata_o,
  output logic        vproc_mem_rvalid_i,
  output logic        vproc_mem_err_i,
  output logic [31:0] vproc_mem_rdata_i,
  input  logic        timer_is_high,
  output logic [31:0] timer_set_val,
  output logic        set_timer,
  output logic        external_storage_spi_cs_n,
  output logic        external_storage_spi_sck,
  output logic        external_storage_spi_mosi,
  input  logic        external_storage_spi_miso,
  input  logic        programming_spi_cs_n,
  input  logic        programming_spi_sck,
  input  logic        programming_spi_mosi,
  output logic        programming_spi_miso,
  inout  wire  [9:0]  gpio_pins
);

  localparam int AW = $clog2(SRAM_WORDS);

  mem_req_t     cpu;
  target_t      tgt;
  logic         blocked, accept, flash_start, cpu_sram_we;
  logic [AW-1:0] cpu_idx;
  logic         flash_busy, flash_done;
  logic [31:0]  flash_data;

  assign cpu = '{addr: vproc_mem_addr_o, we: vproc_mem_we_o, be: vproc_mem_be_o,
                 wdata: vproc_mem_wdata_o};
  assign tgt         = decode(cpu.addr);
  assign blocked     = set_programming_mode | set_debug_mode;
  // Requests arriving while a flash read is in flight vanish without a response.
  assign accept      = vproc_mem_req_o & ~flash_busy;
  assign flash_start = accept & ~blocked & (tgt == T_FLASH) & ~cpu.we;
  assign cpu_sram_we = accept & ~blocked & (tgt == T_SRAM) & cpu.we;
  assign cpu_idx     = cpu.addr[AW+1:2];

  spi_flash_reader #(.SPI_CLK_DIV(SPI_CLK_DIV)) u_flash (
    .clk   (clk),
    .rst   (rst),
    .start (flash_start),
    .addr  (cpu.addr[23:0]),
    .busy  (flash_busy),
    .done  (flash_done),
    .data  (flash_data),
    .cs_n  (external_storage_spi_cs_n),
    .sck   (external_storage_spi_sck),
    .mosi  (external_storage_spi_mosi),
    .miso  (external_storage_spi_miso)
  );

  // ---------------- GPIO ----------------
  logic [9:0]       gpio_out, gpio_oe;
  logic [1:0][9:0]  gpio_sync;

  for (genvar i = 0; i < 10; i++) begin : g_gpio
    assign gpio_pins[i] = gpio_oe[i] ? gpio_out[i] : 1'bz;
  end

  always_ff @(posedge clk) begin
    if (rst) gpio_sync <= '0;
    else     gpio_sync <= {gpio_sync[0], gpio_pins};
  end

  // ---------------- SPI slave ----------------
  logic [2:0]    sck_s;
  logic [1:0]    cs_s, mosi_s;
  logic          slv_rise, slv_fall, slv_cs_n, prog_mode, dbg_mode, slv_we;
  logic [5:0]    slv_cnt;
  logic [30:0]   slv_shift;
  logic [31:0]   slv_word, slv_tx;
  logic [AW-1:0] slv_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s  <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], programming_spi_sck};
      cs_s   <= {cs_s[0], programming_spi_cs_n};
      mosi_s <= {mosi_s[0], programming_spi_mosi};
    end
  end

  // sck_s[2] is the previous synchronized sck, used only for edge detection.
  assign slv_rise  = sck_s[1] & ~sck_s[2];
  assign slv_fall  = ~sck_s[1] & sck_s[2];
  assign slv_cs_n  = cs_s[1];
  assign slv_word  = {slv_shift, mosi_s[1]};
  assign prog_mode = set_programming_mode;
  assign dbg_mode  = set_debug_mode & ~set_programming_mode;
  assign slv_we    = ~rst & prog_mode & ~slv_cs_n & slv_rise & (slv_cnt == 6'd63);

  // ---------------- SRAM ----------------
  logic [31:0] sram [SRAM_WORDS];

  // Slave writes win; the CPU is blocked whenever the slave can write.
  always_ff @(posedge clk) begin
    if (slv_we) sram[slv_idx] <= slv_word;
    else if (cpu_sram_we && !rst) begin
      for (int b = 0; b < 4; b++)
        if (cpu.be[b]) sram[cpu_idx][8*b +: 8] <= cpu.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || slv_cs_n) begin
      slv_cnt              <= '0;
      slv_shift            <= '0;
      slv_idx              <= '0;
      slv_tx               <= '0;
      programming_spi_miso <= 1'b0;
    end else begin
      if (slv_rise) begin
        slv_shift <= slv_word[30:0];
        slv_cnt   <= slv_cnt + 6'd1;
        if (slv_cnt == 6'd31) begin
          slv_idx <= slv_word[AW+1:2];
          slv_tx  <= sram[slv_word[AW+1:2]];
        end
      end
      // The upper half of the 64-bit frame (slv_cnt[5]) is the readback window.
      if (slv_fall) begin
        programming_spi_miso <= dbg_mode & slv_cnt[5] & slv_tx[31];
        if (slv_cnt[5]) slv_tx <= {slv_tx[30:0], 1'b0};
      end
    end
  end

  // ---------------- CPU response ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vproc_mem_rvalid_i <= 1'b0;
      vproc_mem_err_i    <= 1'b0;
      vproc_mem_rdata_i  <= '0;
      gpio_out           <= '0;
      gpio_oe            <= '0;
      timer_set_val      <= '0;
      set_timer          <= 1'b0;
    end else begin
      vproc_mem_rvalid_i <= 1'b0;
      vproc_mem_err_i    <= 1'b0;
      vproc_mem_rdata_i  <= '0;
      set_timer          <= 1'b0;
      if (flash_done) begin
        vproc_mem_rvalid_i <= 1'b1;
        vproc_mem_rdata_i  <= flash_data;
      end else if (accept) begin
        vproc_mem_rvalid_i <= ~flash_start;
        if (blocked) vproc_mem_err_i <= 1'b1;
        else begin
          unique case (tgt)
            T_SRAM:     if (!cpu.we) vproc_mem_rdata_i <= sram[cpu_idx];
            T_GPIO_OUT: if (cpu.we) gpio_out <= cpu.wdata[9:0];
                        else vproc_mem_rdata_i <= {22'b0, gpio_out};
            T_GPIO_OE:  if (cpu.we) gpio_oe <= cpu.wdata[9:0];
                        else vproc_mem_rdata_i <= {22'b0, gpio_oe};
            T_GPIO_IN:  if (cpu.we) vproc_mem_err_i <= 1'b1;
                        else vproc_mem_rdata_i <= {22'b0, gpio_sync[1]};
            T_TIMER:    if (cpu.we) begin
                          timer_set_val <= cpu.wdata;
                          set_timer     <= 1'b1;
                        end else vproc_mem_rdata_i <= {31'b0, timer_is_high};
            T_FLASH:    if (cpu.we) vproc_mem_err_i <= 1'b1;
            default:    vproc_mem_err_i <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mmu.sv
// Directed bench for mmu: CPU bus accesses, GPIO pads, timer, flash model,
// SPI slave programming/debug frames and reset abort.
module tb_mmu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, prog, dbg, req, we, timer_is_high;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rvalid, err, set_timer;
  logic [31:0] rdata, timer_set_val;
  logic        fl_cs_n, fl_sck, fl_mosi;
  logic        fl_miso = 1'b0;
  logic        p_cs_n, p_sck, p_mosi, p_miso;
  wire  [9:0]  gpio_pins;
  logic        ext_en;
  logic [9:0]  ext_val;

  assign gpio_pins = ext_en ? ext_val : 10'bz;

  int errors = 0;
  int checks = 0;

  mmu dut (
    .clk                       (clk),
    .rst                       (rst),
    .set_programming_mode      (prog),
    .set_debug_mode            (dbg),
    .vproc_mem_req_o           (req),
    .vproc_mem_addr_o          (addr),
    .vproc_mem_we_o            (we),
    .vproc_mem_be_o            (be),
    .vproc_mem_wdata_o         (wdata),
    .vproc_mem_rvalid_i        (rvalid),
    .vproc_mem_err_i           (err),
    .vproc_mem_rdata_i         (rdata),
    .timer_is_high             (timer_is_high),
    .timer_set_val             (timer_set_val),
    .set_timer                 (set_timer),
    .external_storage_spi_cs_n (fl_cs_n),
    .external_storage_spi_sck  (fl_sck),
    .external_storage_spi_mosi (fl_mosi),
    .external_storage_spi_miso (fl_miso),
    .programming_spi_cs_n      (p_cs_n),
    .programming_spi_sck       (p_sck),
    .programming_spi_mosi      (p_mosi),
    .programming_spi_miso      (p_miso),
    .gpio_pins                 (gpio_pins)
  );

  // Flash model: captures cmd+addr on rising sck, returns bytes 11,22,33,44.
  int          fl_cnt = 0;
  logic [31:0] fl_cmd = '0;
  logic [31:0] fl_stream = 32'h1122_3344;
  logic        fl_sck_q = 1'b0;

  always @(negedge clk) begin
    if (fl_cs_n) begin
      fl_cnt  = 0;
      fl_miso = 1'b0;
    end else if (fl_sck && !fl_sck_q) begin
      if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], fl_mosi};
      fl_cnt++;
    end else if (!fl_sck && fl_sck_q && fl_cnt >= 32 && fl_cnt < 64) begin
      fl_miso = fl_stream[5'(63 - fl_cnt)];
    end
    fl_sck_q = fl_sck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic exp_err, input logic [31:0] exp_data);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".rdata"}, rdata, exp_data);
  endtask

  // One-cycle request; returns on the negedge where a 1-cycle response is visible.
  task automatic cpu(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  localparam int SH = 6;

  task automatic spi_bit(input logic b, output logic r);
    p_mosi = b;
    repeat (SH) @(negedge clk);
    r = p_miso;
    p_sck = 1'b1;
    repeat (SH) @(negedge clk);
    p_sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [63:0] tx, output logic [31:0] rx);
    logic r;
    rx = '0;
    p_cs_n = 1'b0;
    repeat (SH) @(negedge clk);
    for (int i = 63; i >= 0; i--) begin
      spi_bit(tx[i], r);
      if (i < 32) rx[i] = r;
    end
    repeat (SH) @(negedge clk);
    p_cs_n = 1'b1;
    repeat (SH) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rx;
    int n;
    rst = 1'b1; prog = 1'b0; dbg = 1'b0; req = 1'b0; we = 1'b0; be = '0;
    addr = '0; wdata = '0; timer_is_high = 1'b0;
    p_cs_n = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; ext_en = 1'b0; ext_val = '0;
    repeat (3) @(negedge clk);

    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.fl_cs_n", 32'(fl_cs_n), 32'd1);
    chk("rst.fl_sck", 32'(fl_sck), 32'd0);
    chk("rst.fl_mosi", 32'(fl_mosi), 32'd0);
    chk("rst.timer_val", timer_set_val, 32'd0);
    chk("rst.set_timer", 32'(set_timer), 32'd0);
    chk("rst.p_miso", 32'(p_miso), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // SRAM with byte enables
    cpu(32'h10, 1'b1, 4'hF, 32'h0);          chk_resp("sram_clr", 1'b0, 32'h0);
    cpu(32'h10, 1'b1, 4'b0011, 32'hDEADBEEF); chk_resp("sram_wr", 1'b0, 32'h0);
    cpu(32'h10, 1'b0, 4'hF, 32'h0);          chk_resp("sram_rd", 1'b0, 32'h0000BEEF);
    @(negedge clk);
    chk("sram_rvalid_pulse", 32'(rvalid), 32'd0);
    cpu(32'h13, 1'b0, 4'hF, 32'h0);          chk_resp("sram_rd_lowbits", 1'b0, 32'h0000BEEF);

    // GPIO
    cpu(32'h1000_0004, 1'b1, 4'h0, 32'h3FF);      chk_resp("gpio_oe_wr", 1'b0, 32'h0);
    cpu(32'h1000_0000, 1'b1, 4'h0, 32'hFFFF_F155); chk_resp("gpio_out_wr", 1'b0, 32'h0);
    @(negedge clk);
    chk("gpio_pins_drive", {22'b0, gpio_pins}, 32'h155);
    cpu(32'h1000_0000, 1'b0, 4'h0, 32'h0);        chk_resp("gpio_out_rd", 1'b0, 32'h155);
    cpu(32'h1000_0004, 1'b1, 4'h0, 32'h0);        chk_resp("gpio_oe_clr", 1'b0, 32'h0);
    ext_val = 10'h2AA; ext_en = 1'b1;
    repeat (3) @(negedge clk);
    cpu(32'h1000_0008, 1'b0, 4'h0, 32'h0);        chk_resp("gpio_in_rd", 1'b0, 32'h2AA);
    cpu(32'h1000_0008, 1'b1, 4'hF, 32'hFFFF);     chk_resp("gpio_in_wr_err", 1'b1, 32'h0);
    ext_en = 1'b0;

    // Timer
    timer_is_high = 1'b1;
    cpu(32'h2000_0000, 1'b1, 4'h0, 32'h1234);     chk_resp("timer_wr", 1'b0, 32'h0);
    chk("timer_set_hi", 32'(set_timer), 32'd1);
    chk("timer_val", timer_set_val, 32'h1234);
    @(negedge clk);
    chk("timer_set_lo", 32'(set_timer), 32'd0);
    cpu(32'h2000_0000, 1'b0, 4'h0, 32'h0);        chk_resp("timer_rd", 1'b0, 32'h1);

    // Flash read, with a request dropped while busy
    cpu(32'h3000_0100, 1'b0, 4'hF, 32'h0);
    chk("flash_cs_low", 32'(fl_cs_n), 32'd0);
    chk("flash_no_early_rvalid", 32'(rvalid), 32'd0);
    repeat (4) @(negedge clk);
    cpu(32'h1000_0000, 1'b1, 4'h0, 32'h0AA);
    n = 0;
    while (!rvalid && n < 400) begin @(negedge clk); n++; end
    chk("flash_timeout", 32'(n < 400), 32'd1);
    chk_resp("flash_rd", 1'b0, 32'h44332211);
    chk("flash_cmd_addr", fl_cmd, 32'h0300_0100);
    chk("flash_cs_high", 32'(fl_cs_n), 32'd1);
    @(negedge clk);
    cpu(32'h1000_0000, 1'b0, 4'h0, 32'h0);        chk_resp("busy_drop", 1'b0, 32'h155);

    // Reserved and illegal accesses
    cpu(32'h4000_0000, 1'b0, 4'hF, 32'h0);        chk_resp("rsvd_rd", 1'b1, 32'h0);
    cpu(32'h3000_0000, 1'b1, 4'hF, 32'h1);        chk_resp("flash_wr_err", 1'b1, 32'h0);
    chk("flash_wr_no_cs", 32'(fl_cs_n), 32'd1);
    prog = 1'b1;
    cpu(32'h10, 1'b1, 4'hF, 32'hFFFF_FFFF);       chk_resp("blocked_wr", 1'b1, 32'h0);
    prog = 1'b0;
    cpu(32'h10, 1'b0, 4'hF, 32'h0);               chk_resp("blocked_no_effect", 1'b0, 32'h0000BEEF);

    // SPI slave programming then debug readback
    prog = 1'b1;
    spi_frame({32'h20, 32'hCAFEF00D}, rx);
    prog = 1'b0;
    cpu(32'h20, 1'b0, 4'hF, 32'h0);               chk_resp("prog_rd", 1'b0, 32'hCAFEF00D);
    dbg = 1'b1;
    spi_frame({32'h20, 32'h0}, rx);
    chk("dbg_miso_word", rx, 32'hCAFEF00D);
    chk("dbg_miso_idle", 32'(p_miso), 32'd0);
    dbg = 1'b0;

    // Reset during a flash transfer aborts it without a response
    cpu(32'h3000_0000, 1'b0, 4'hF, 32'h0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 32'(fl_cs_n), 32'd1);
    chk("abort_sck", 32'(fl_sck), 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (rvalid) n++;
    end
    chk("abort_no_rvalid", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
